mux_path_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the shared 2:1 mux + D-register datapath.
//   Two requesters (A, B) each present data with a valid/ready handshake. The block drives
//   the mux select, grants one requester at a time, and registers the selected word into
//   a single output stage with its own valid/ready. It sits between the request sources
//   and the downstream consumer of the registered mux output.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mux_out_stage.sv | 42 ++++
 rtl/mux_path_arbiter.sv | 128 ++++++++++++
 tb/tb_mux_path_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state and select encodings for the mux path arbiter
//   (package only, no ports)
package mux_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_A = 2'd1;
  localparam logic [1:0] ST_SERVE_B = 2'd2;

  // Mux select values; also used to record which side was served last
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_out_stage.sv
// rtl/mux_out_stage.sv - 2:1 data mux feeding a valid/ready output register
//   clk, rst_n          clock, async active-low reset
//   sel                 0 = a_data, 1 = b_data
//   a_data, b_data      candidate words
//   load                an accepted beat this cycle; capture the selected word
//   out_ready           consumer accepts the held word
//   out_valid, out_data registered output word
module mux_out_stage
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             load,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mux_data;

  assign mux_data = (sel == SEL_B) ? b_data : a_data;

  // A load only happens when the register has space, so loading always wins;
  // otherwise a consume empties the register and the data is simply held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_path_arbiter.sv
// rtl/mux_path_arbiter.sv - round-robin arbiter/sequencer for a shared 2:1 mux + output register
//   clk, rst_n                  clock, async active-low reset
//   a_valid, a_data, a_ready    requester A handshake
//   b_valid, b_data, b_ready    requester B handshake
//   out_valid, out_data,        registered mux output handshake
//   out_ready
//   sel                         mux select (0 = A, 1 = B)
//   gnt_a, gnt_b                current path owner
module mux_path_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b
);

  localparam int CW = $clog2(MAX_BURST + 1);
  // The counter wraps instead of storing MAX_BURST: a beat taken while the
  // count equals BURST_LAST is the beat that completes the burst.
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  logic [1:0]    state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;
  logic          space, a_beat, b_beat;

  // Grants and select decode straight from the state register, so they are glitch-free
  assign gnt_a = (state == ST_SERVE_A);
  assign gnt_b = (state == ST_SERVE_B);
  assign sel   = gnt_b ? SEL_B : SEL_A;

  assign space   = !out_valid || out_ready;
  assign a_ready = gnt_a && space;
  assign b_ready = gnt_b && space;
  assign a_beat  = a_valid && a_ready;
  assign b_beat  = b_valid && b_ready;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = burst_cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        // On a tie the side that was not served last wins
        if (a_valid && (!b_valid || last == SEL_B)) state_nxt = ST_SERVE_A;
        else if (b_valid)                           state_nxt = ST_SERVE_B;
      end
      ST_SERVE_A: begin
        if (!a_valid) begin
          state_nxt = b_valid ? ST_SERVE_B : ST_IDLE;
          last_nxt  = SEL_A;
          cnt_nxt   = '0;
        end else if (a_beat) begin
          if (burst_cnt == BURST_LAST) begin
            cnt_nxt = '0;
            if (b_valid) begin
              state_nxt = ST_SERVE_B;
              last_nxt  = SEL_A;
            end
          end else begin
            cnt_nxt = burst_cnt + CW'(1);
          end
        end
      end
      ST_SERVE_B: begin
        if (!b_valid) begin
          state_nxt = a_valid ? ST_SERVE_A : ST_IDLE;
          last_nxt  = SEL_B;
          cnt_nxt   = '0;
        end else if (b_beat) begin
          if (burst_cnt == BURST_LAST) begin
            cnt_nxt = '0;
            if (a_valid) begin
              state_nxt = ST_SERVE_A;
              last_nxt  = SEL_B;
            end
          end else begin
            cnt_nxt = burst_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= SEL_B;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  mux_out_stage #(.WIDTH(WIDTH)) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .a_data    (a_data),
    .b_data    (b_data),
    .load      (a_beat || b_beat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_mux_path_arbiter.sv
// tb/tb_mux_path_arbiter.sv - self-checking bench for mux_path_arbiter
module tb_mux_path_arbiter;

  localparam int W    = 4;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, sel, gnt_a, gnt_b;
  logic [W-1:0] out_data;

  int total = 0;
  int bad   = 0;

  // Reference model: owner 0 = none, 1 = A, 2 = B; last uses the same ids
  int           m_owner, m_last, m_cnt;
  logic         m_ov;
  logic [W-1:0] m_od;
  logic         acc_a, acc_b;

  mux_path_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_cnt = 0; m_ov = 1'b0; m_od = '0;
    acc_a = 1'b0; acc_b = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, wait for the next falling edge
  task automatic cyc(input logic av, input logic [W-1:0] ad,
                     input logic bv, input logic [W-1:0] bd, input logic ordy);
    logic space, era, erb, mine, other;
    int   oth_id;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
    space = !m_ov || ordy;
    era   = (m_owner == 1) && space;
    erb   = (m_owner == 2) && space;
    chk1("a_ready",   a_ready,   era);
    chk1("b_ready",   b_ready,   erb);
    chk1("gnt_a",     gnt_a,     m_owner == 1);
    chk1("gnt_b",     gnt_b,     m_owner == 2);
    chk1("sel",       sel,       m_owner == 2);
    chk1("out_valid", out_valid, m_ov);
    chk4("out_data",  out_data,  m_od);
    acc_a = av && era;
    acc_b = bv && erb;
    if (acc_a || acc_b) begin
      m_ov = 1'b1;
      m_od = acc_a ? ad : bd;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (m_owner == 0) begin
      m_cnt = 0;
      if (av && bv)  m_owner = (m_last == 1) ? 2 : 1;
      else if (av)   m_owner = 1;
      else if (bv)   m_owner = 2;
    end else begin
      mine   = (m_owner == 1) ? av : bv;
      other  = (m_owner == 1) ? bv : av;
      oth_id = 3 - m_owner;
      if (!mine) begin
        m_last  = m_owner;
        m_owner = other ? oth_id : 0;
        m_cnt   = 0;
      end else if (acc_a || acc_b) begin
        m_cnt++;
        if (m_cnt == MAXB) begin
          m_cnt = 0;
          if (other) begin
            m_last  = m_owner;
            m_owner = oth_id;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] da, db, ra_d, rb_d;
    logic         ra_v, rb_v;
    int           toggles, a_run;
    logic         prev_sel;

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk4("rst_out_data",  out_data,  '0);
    chk1("rst_gnt_a",     gnt_a,     1'b0);
    chk1("rst_gnt_b",     gnt_b,     1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // First tie after reset goes to A
    cyc(1'b1, 4'h5, 1'b1, 4'h6, 1'b1);
    chk1("tie1_gnt_a", gnt_a, 1'b1);
    cyc(1'b1, 4'h5, 1'b1, 4'h6, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 4'h6, 1'b1);
    chk1("release_to_b", gnt_b, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 4'h6, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // A alone sends 1,2,3
    cyc(1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
    chk4("a_seq_1", out_data, 4'h1);
    cyc(1'b1, 4'h2, 1'b0, 4'h0, 1'b1);
    chk4("a_seq_2", out_data, 4'h2);
    cyc(1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
    chk4("a_seq_3", out_data, 4'h3);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // A was served last, so the next tie goes to B
    cyc(1'b1, 4'h7, 1'b1, 4'h8, 1'b1);
    chk1("tie2_gnt_b", gnt_b, 1'b1);
    cyc(1'b1, 4'h7, 1'b1, 4'h8, 1'b1);
    cyc(1'b1, 4'h7, 1'b0, 4'h0, 1'b0);

    // Output stall holds 0xA for three cycles
    cyc(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'hB, 1'b0, 4'h0, 1'b0);
      chk4("hold_data", out_data, 4'hA);
    end
    cyc(1'b1, 4'hB, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Both always valid: grants alternate in bursts of MAXB
    da = 4'h0; db = 4'h8; toggles = 0;
    cyc(1'b1, da, 1'b1, db, 1'b1);
    prev_sel = sel;
    for (int i = 0; i < 4 * MAXB; i++) begin
      cyc(1'b1, da, 1'b1, db, 1'b1);
      if (acc_a) da = da + 4'h1;
      if (acc_b) db = db + 4'h1;
      if (sel !== prev_sel) toggles++;
      prev_sel = sel;
    end
    chk_int("sel_toggles", toggles, 4);

    // Asynchronous reset mid-burst, checked with no clock edge
    chk1("pre_reset_ov", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("async_out_valid", out_valid, 1'b0);
    chk1("async_gnt_a",     gnt_a,     1'b0);
    chk1("async_gnt_b",     gnt_b,     1'b0);
    chk1("async_sel",       sel,       1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // B drops mid-burst with A idle, then A regrant gets a full burst
    cyc(1'b0, 4'h0, 1'b1, 4'h1, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 4'h1, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 4'h2, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk1("drop_idle_gnt_b", gnt_b, 1'b0);
    chk1("drop_idle_gnt_a", gnt_a, 1'b0);
    cyc(1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
    a_run = 0; da = 4'h3;
    for (int i = 0; i < 3 * MAXB && !gnt_b; i++) begin
      cyc(1'b1, da, 1'b1, 4'hE, 1'b1);
      if (acc_a) begin a_run++; da = da + 4'h1; end
    end
    chk_int("regrant_burst", a_run, MAXB);
    cyc(1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Random traffic: a requester holds its word until the model says it was accepted
    ra_v = 1'b0; rb_v = 1'b0; ra_d = '0; rb_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ra_v) begin ra_v = ($urandom_range(0, 99) < 70); ra_d = 4'($urandom); end
      if (!rb_v) begin rb_v = ($urandom_range(0, 99) < 70); rb_d = 4'($urandom); end
      cyc(ra_v, ra_d, rb_v, rb_d, $urandom_range(0, 99) < 75);
      if (acc_a) ra_v = 1'b0;
      if (acc_b) rb_v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
